axi_ram_wr_intf_ctl: RTL and testbench

AXI write-channel slave (AW/W/B) that converts AXI write bursts into a single-port RAM write strobe interface. It is the write-direction companion of the read-side RAM interface controller and sits between the AXI master and the RAM macro. The block accepts one outstanding burst, steps the address per beat, forwards data and byte strobes, and returns one B response per burst.

---
 rtl/axi_ram_wr_intf_ctl.sv | 150 +++++++++++++++
 tb/tb_axi_ram_wr_intf_ctl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_ram_wr_intf_ctl.sv
// AXI write-channel slave (AW/W/B) driving a single-port RAM write strobe interface.
// One outstanding burst; address stepped per accepted beat, one B response per burst.
module axi_ram_wr_intf_ctl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
) (
    input  logic                clock,
    input  logic                reset,
    output logic                io_axi_mst_aw_chl_ready,
    input  logic                io_axi_mst_aw_chl_valid,
    input  logic [ID_W-1:0]     io_axi_mst_aw_chl_bits_awid,
    input  logic [ADDR_W-1:0]   io_axi_mst_aw_chl_bits_awaddr,
    input  logic [2:0]          io_axi_mst_aw_chl_bits_awsize,
    input  logic [3:0]          io_axi_mst_aw_chl_bits_awlen,
    input  logic [1:0]          io_axi_mst_aw_chl_bits_awburst,
    input  logic [1:0]          io_axi_mst_aw_chl_bits_awlock,
    input  logic [1:0]          io_axi_mst_aw_chl_bits_awcache,
    input  logic [1:0]          io_axi_mst_aw_chl_bits_awprot,
    output logic                io_axi_mst_w_chl_ready,
    input  logic                io_axi_mst_w_chl_valid,
    input  logic [DATA_W-1:0]   io_axi_mst_w_chl_bits_wdata,
    input  logic [DATA_W/8-1:0] io_axi_mst_w_chl_bits_wstrb,
    input  logic                io_axi_mst_w_chl_bits_wlast,
    input  logic                io_axi_mst_b_chl_ready,
    output logic                io_axi_mst_b_chl_valid,
    output logic [ID_W-1:0]     io_axi_mst_b_chl_bits_bid,
    output logic [1:0]          io_axi_mst_b_chl_bits_bresp,
    output logic [ADDR_W-1:0]   io_adr,
    output logic                io_wen,
    output logic [DATA_W-1:0]   io_wdat,
    output logic [DATA_W/8-1:0] io_wstrb,
    input  logic                io_wrdy
);

    localparam int STRB_W   = DATA_W / 8;
    localparam int MAX_SIZE = $clog2(STRB_W);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_RESP
    } state_t;

    state_t            r_state;
    logic [ID_W-1:0]   r_id;
    logic [ADDR_W-1:0] r_addr;
    logic [2:0]        r_size;
    logic [3:0]        r_len;
    logic [1:0]        r_burst;
    logic [3:0]        r_cnt;
    logic              r_err;

    logic              w_aw_hs;
    logic              w_beat;
    logic              w_last;
    logic              w_aw_err;
    logic              w_wrap_ok;
    logic [ADDR_W-1:0] w_step;
    logic [ADDR_W-1:0] w_bnd;
    logic [ADDR_W-1:0] w_next_addr;
    logic              w_unused;

    assign w_unused = ^{io_axi_mst_aw_chl_bits_awlock, io_axi_mst_aw_chl_bits_awcache,
                        io_axi_mst_aw_chl_bits_awprot};

    assign io_axi_mst_aw_chl_ready = (r_state == S_IDLE) && !reset;
    assign io_axi_mst_w_chl_ready  = (r_state == S_DATA) && io_wrdy;
    assign io_axi_mst_b_chl_valid  = (r_state == S_RESP);
    assign io_axi_mst_b_chl_bits_bid   = r_id;
    assign io_axi_mst_b_chl_bits_bresp = ((r_state == S_RESP) && r_err) ? 2'b10 : 2'b00;

    assign w_aw_hs = io_axi_mst_aw_chl_valid && io_axi_mst_aw_chl_ready;
    assign w_beat  = io_axi_mst_w_chl_valid && io_axi_mst_w_chl_ready;
    assign w_last  = (r_cnt == r_len);

    // RAM sees the beat on the same edge it is accepted, so data and strobes pass straight through
    assign io_wen   = w_beat;
    assign io_adr   = r_addr;
    assign io_wdat  = (r_state == S_DATA) ? io_axi_mst_w_chl_bits_wdata : '0;
    assign io_wstrb = (r_state == S_DATA) ? io_axi_mst_w_chl_bits_wstrb : '0;

    assign w_aw_err = (32'(io_axi_mst_aw_chl_bits_awsize) > MAX_SIZE)
                   || (io_axi_mst_aw_chl_bits_awburst == 2'b11)
                   || ((io_axi_mst_aw_chl_bits_awburst == 2'b10)
                       && !(io_axi_mst_aw_chl_bits_awlen inside {4'd1, 4'd3, 4'd7, 4'd15}));

    assign w_wrap_ok = (r_burst == 2'b10) && (r_len inside {4'd1, 4'd3, 4'd7, 4'd15});
    assign w_step    = ADDR_W'(1) << r_size;
    assign w_bnd     = (ADDR_W'(r_len) + ADDR_W'(1)) << r_size;

    // Illegal wrap lengths and the reserved burst type fall back to incrementing
    always_comb begin
        w_next_addr = r_addr + w_step;
        if (r_burst == 2'b00) begin
            w_next_addr = r_addr;
        end else if (w_wrap_ok) begin
            w_next_addr = (r_addr & ~(w_bnd - ADDR_W'(1)))
                        | ((r_addr + w_step) & (w_bnd - ADDR_W'(1)));
        end
    end

    // The beat counter, not wlast, ends the burst; a wlast disagreement only poisons bresp
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_id    <= '0;
            r_addr  <= '0;
            r_size  <= '0;
            r_len   <= '0;
            r_burst <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_aw_hs) begin
                        r_id    <= io_axi_mst_aw_chl_bits_awid;
                        r_addr  <= io_axi_mst_aw_chl_bits_awaddr;
                        r_size  <= io_axi_mst_aw_chl_bits_awsize;
                        r_len   <= io_axi_mst_aw_chl_bits_awlen;
                        r_burst <= io_axi_mst_aw_chl_bits_awburst;
                        r_cnt   <= '0;
                        r_err   <= w_aw_err;
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_beat) begin
                        r_cnt  <= r_cnt + 4'd1;
                        r_addr <= w_next_addr;
                        if (io_axi_mst_w_chl_bits_wlast != w_last) begin
                            r_err <= 1'b1;
                        end
                        if (w_last) begin
                            r_state <= S_RESP;
                        end
                    end
                end
                S_RESP: begin
                    if (io_axi_mst_b_chl_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_ram_wr_intf_ctl.sv
// Bench for axi_ram_wr_intf_ctl: directed burst table, randomized bursts against an
// arithmetic address/response model, and a reset-mid-burst sequence.
module tb_axi_ram_wr_intf_ctl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        awReady;
    logic        awValid = 1'b0;
    logic [3:0]  awId = '0;
    logic [31:0] awAddr = '0;
    logic [2:0]  awSize = '0;
    logic [3:0]  awLen = '0;
    logic [1:0]  awBurst = '0;
    logic [1:0]  awLock = '0;
    logic [1:0]  awCache = '0;
    logic [1:0]  awProt = '0;
    logic        wReady;
    logic        wValid = 1'b0;
    logic [31:0] wData = '0;
    logic [3:0]  wStrb = '0;
    logic        wLast = 1'b0;
    logic        bReady = 1'b0;
    logic        bValid;
    logic [3:0]  bId;
    logic [1:0]  bResp;
    logic [31:0] ramAdr;
    logic        ramWen;
    logic [31:0] ramWdat;
    logic [3:0]  ramWstrb;
    logic        ramWrdy = 1'b0;

    int nVectors = 0;
    int nMiscompares = 0;

    typedef struct {
        logic [3:0]       id;
        logic [31:0]      addr;
        logic [2:0]       size;
        logic [3:0]       len;
        logic [1:0]       burst;
        logic             badLast;
        logic [15:0]      vpat;
        logic [15:0]      rpat;
        int               bDelay;
        logic [31:0]      dataSeed;
        logic [3:0]       strb;
        logic [1:0]       expResp;
        logic [3:0][31:0] expAdr;
    } vec_t;

    vec_t tbl [9];

    axi_ram_wr_intf_ctl #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) dut (
        .clock                          (clock),
        .reset                          (reset),
        .io_axi_mst_aw_chl_ready        (awReady),
        .io_axi_mst_aw_chl_valid        (awValid),
        .io_axi_mst_aw_chl_bits_awid    (awId),
        .io_axi_mst_aw_chl_bits_awaddr  (awAddr),
        .io_axi_mst_aw_chl_bits_awsize  (awSize),
        .io_axi_mst_aw_chl_bits_awlen   (awLen),
        .io_axi_mst_aw_chl_bits_awburst (awBurst),
        .io_axi_mst_aw_chl_bits_awlock  (awLock),
        .io_axi_mst_aw_chl_bits_awcache (awCache),
        .io_axi_mst_aw_chl_bits_awprot  (awProt),
        .io_axi_mst_w_chl_ready         (wReady),
        .io_axi_mst_w_chl_valid         (wValid),
        .io_axi_mst_w_chl_bits_wdata    (wData),
        .io_axi_mst_w_chl_bits_wstrb    (wStrb),
        .io_axi_mst_w_chl_bits_wlast    (wLast),
        .io_axi_mst_b_chl_ready         (bReady),
        .io_axi_mst_b_chl_valid         (bValid),
        .io_axi_mst_b_chl_bits_bid      (bId),
        .io_axi_mst_b_chl_bits_bresp    (bResp),
        .io_adr                         (ramAdr),
        .io_wen                         (ramWen),
        .io_wdat                        (ramWdat),
        .io_wstrb                       (ramWstrb),
        .io_wrdy                        (ramWrdy)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nVectors++;
        if (act !== exp) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Address of beat n derived directly from the burst rules: fixed, linear, or modulo the wrap window
    function automatic logic [31:0] modelAddr(input logic [31:0] start, input logic [2:0] size,
                                              input logic [3:0] len, input logic [1:0] burst,
                                              input int beat);
        longint step = longint'(1) << size;
        longint s = longint'(start);
        longint bnd;
        longint lower;
        if (burst == 2'b00) return start;
        if (burst == 2'b10 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
            bnd   = (longint'(len) + 1) * step;
            lower = s - (s % bnd);
            return 32'(lower + ((s - lower) + longint'(beat) * step) % bnd);
        end
        return 32'(s + longint'(beat) * step);
    endfunction

    function automatic logic [1:0] modelResp(input logic [2:0] size, input logic [3:0] len,
                                             input logic [1:0] burst, input logic badLast);
        logic err;
        err = (size > 3'd2) || (burst == 2'b11) || badLast
           || (burst == 2'b10 && !(len == 1 || len == 3 || len == 7 || len == 15));
        return err ? 2'b10 : 2'b00;
    endfunction

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_awReady"}, 64'(awReady), 0);
        checkOutput({tag, "_wReady"}, 64'(wReady), 0);
        checkOutput({tag, "_bValid"}, 64'(bValid), 0);
        checkOutput({tag, "_wen"}, 64'(ramWen), 0);
        checkOutput({tag, "_adr"}, 64'(ramAdr), 0);
        checkOutput({tag, "_wdat"}, 64'(ramWdat), 0);
        checkOutput({tag, "_wstrb"}, 64'(ramWstrb), 0);
        checkOutput({tag, "_bid"}, 64'(bId), 0);
        checkOutput({tag, "_bresp"}, 64'(bResp), 0);
    endtask

    task automatic applyStimulus(input vec_t v, input logic [15:0][31:0] exp);
        int waited = 0;
        int beat = 0;
        int cyc = 0;
        @(negedge clock);
        awValid = 1'b1; awId = v.id; awAddr = v.addr; awSize = v.size;
        awLen = v.len; awBurst = v.burst;
        #1;
        while (!awReady && waited < 10) begin
            @(negedge clock); #1; waited++;
        end
        checkOutput("awReady", 64'(awReady), 1);
        while (beat <= int'(v.len) && cyc < 200) begin
            @(negedge clock);
            awValid = 1'b0;
            wValid  = v.vpat[cyc % 16];
            ramWrdy = v.rpat[cyc % 16];
            wData   = v.dataSeed + 32'(beat);
            wStrb   = v.strb;
            wLast   = (beat == int'(v.len)) ^ (v.badLast && beat == 0);
            #1;
            checkOutput("wReadyTracksWrdy", 64'(wReady), 64'(ramWrdy));
            if (wValid && ramWrdy) begin
                checkOutput("wen", 64'(ramWen), 1);
                checkOutput($sformatf("adr_beat%0d", beat), 64'(ramAdr), 64'(exp[beat]));
                checkOutput("wdat", 64'(ramWdat), 64'(wData));
                checkOutput("wstrb", 64'(ramWstrb), 64'(wStrb));
                beat++;
            end else begin
                checkOutput("wenIdle", 64'(ramWen), 0);
            end
            cyc++;
        end
        checkOutput("beatsCompleted", 64'(beat), 64'(int'(v.len) + 1));
        for (int d = 0; d < v.bDelay; d++) begin
            @(negedge clock);
            wValid = 1'b1; ramWrdy = 1'b1; bReady = 1'b0;
            #1;
            checkOutput("bValidHeld", 64'(bValid), 1);
            checkOutput("bidHeld", 64'(bId), 64'(v.id));
            checkOutput("brespHeld", 64'(bResp), 64'(v.expResp));
            checkOutput("awReadyInResp", 64'(awReady), 0);
            checkOutput("extraBeatRejected", 64'({wReady, ramWen}), 0);
        end
        @(negedge clock);
        wValid = 1'b0; bReady = 1'b1;
        #1;
        checkOutput("bValid", 64'(bValid), 1);
        checkOutput("bid", 64'(bId), 64'(v.id));
        checkOutput("bresp", 64'(bResp), 64'(v.expResp));
        @(negedge clock);
        bReady = 1'b0;
        #1;
        checkOutput("bValidAfterHs", 64'(bValid), 0);
        checkOutput("awReadyAfterHs", 64'(awReady), 1);
    endtask

    task automatic runTable(input int idx);
        logic [15:0][31:0] exp = '0;
        for (int i = 0; i < 4; i++) exp[i] = tbl[idx].expAdr[i];
        applyStimulus(tbl[idx], exp);
    endtask

    initial begin
        vec_t rv;
        logic [15:0][31:0] rexp;

        tbl[0] = '{4'h3, 32'h100, 3'd2, 4'd3, 2'b01, 1'b0, 16'hFFFF, 16'hFFFF, 0, 32'hA0, 4'hF, 2'b00,
                   {32'h10C, 32'h108, 32'h104, 32'h100}};
        tbl[1] = '{4'h5, 32'h108, 3'd2, 4'd3, 2'b10, 1'b0, 16'hFFFF, 16'hFFFF, 0, 32'hB0, 4'hF, 2'b00,
                   {32'h104, 32'h100, 32'h10C, 32'h108}};
        tbl[2] = '{4'h1, 32'h40, 3'd2, 4'd2, 2'b00, 1'b0, 16'hFFFF, 16'h5555, 0, 32'hC0, 4'h5, 2'b00,
                   {32'h0, 32'h40, 32'h40, 32'h40}};
        tbl[3] = '{4'h2, 32'h200, 3'd2, 4'd1, 2'b01, 1'b1, 16'hFFFF, 16'hFFFF, 0, 32'hD0, 4'hF, 2'b10,
                   {32'h0, 32'h0, 32'h204, 32'h200}};
        tbl[4] = '{4'h4, 32'h300, 3'd2, 4'd1, 2'b11, 1'b0, 16'hFFFF, 16'hFFFF, 0, 32'hE0, 4'h3, 2'b10,
                   {32'h0, 32'h0, 32'h304, 32'h300}};
        tbl[5] = '{4'hA, 32'h20, 3'd2, 4'd0, 2'b01, 1'b0, 16'hFFFF, 16'hFFFF, 5, 32'hF0, 4'hC, 2'b00,
                   {32'h0, 32'h0, 32'h0, 32'h20}};
        tbl[6] = '{4'h6, 32'h10, 3'd2, 4'd2, 2'b10, 1'b0, 16'hFFFF, 16'hFFFF, 1, 32'h11, 4'hF, 2'b10,
                   {32'h0, 32'h18, 32'h14, 32'h10}};
        tbl[7] = '{4'h7, 32'h0, 3'd3, 4'd1, 2'b01, 1'b0, 16'hFFFF, 16'hFFFF, 0, 32'h22, 4'hF, 2'b10,
                   {32'h0, 32'h0, 32'h8, 32'h0}};
        tbl[8] = '{4'h9, 32'h6, 3'd1, 4'd1, 2'b10, 1'b0, 16'hFFFF, 16'hFFFF, 0, 32'h33, 4'hC, 2'b00,
                   {32'h0, 32'h0, 32'h4, 32'h6}};

        #2;
        checkAllZero("reset");
        @(negedge clock);
        reset = 1'b0;
        #1;
        checkOutput("awReadyAfterReset", 64'(awReady), 1);

        for (int i = 0; i < 9; i++) runTable(i);

        for (int n = 0; n < 20; n++) begin
            rv.id       = 4'($urandom);
            rv.addr     = $urandom & 32'h0000FFFF;
            rv.size     = ($urandom_range(0, 7) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
            rv.len      = 4'($urandom_range(0, 15));
            rv.burst    = 2'($urandom_range(0, 3));
            rv.badLast  = ($urandom_range(0, 4) == 0);
            rv.vpat     = 16'($urandom) | 16'h0001;
            rv.rpat     = 16'($urandom) | 16'h0001;
            rv.bDelay   = $urandom_range(0, 3);
            rv.dataSeed = $urandom;
            rv.strb     = 4'($urandom);
            rv.expResp  = modelResp(rv.size, rv.len, rv.burst, rv.badLast);
            rv.expAdr   = '0;
            rexp        = '0;
            for (int b = 0; b < 16; b++) rexp[b] = modelAddr(rv.addr, rv.size, rv.len, rv.burst, b);
            applyStimulus(rv, rexp);
        end

        // Reset two beats into a four-beat burst: everything drops at once, no response follows
        @(negedge clock);
        awValid = 1'b1; awId = 4'h8; awAddr = 32'h500; awSize = 3'd2; awLen = 4'd3; awBurst = 2'b01;
        for (int b = 0; b < 2; b++) begin
            @(negedge clock);
            awValid = 1'b0; wValid = 1'b1; ramWrdy = 1'b1;
            wData = 32'h55 + 32'(b); wStrb = 4'hF; wLast = 1'b0;
            #1;
            checkOutput("preResetWen", 64'(ramWen), 1);
            checkOutput("preResetAdr", 64'(ramAdr), 64'(32'h500 + 32'(4 * b)));
        end
        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        checkAllZero("midReset");
        @(negedge clock);
        reset = 1'b0; wValid = 1'b0; ramWrdy = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            checkOutput("noRespAfterReset", 64'(bValid), 0);
            checkOutput("idleAfterReset", 64'(awReady), 1);
            @(negedge clock);
        end
        runTable(0);

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
